fp_addsub_pipe: RTL
===================

# fp_addsub_pipe

Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor with valid/ready handshakes on both sides. It replaces the one-operand-port, multi-cycle single-precision adder: both operands and an add/sub select arrive in one beat, results stream out at one per cycle, and the block adds round-to-nearest-even and exception flags. It sits between the operand sequencer and the result collector in the FP datapath.

## Interface
- EXP_W, 8, exponent field width (min 4)
- MAN_W, 23, stored fraction width, hidden bit excluded (min 4)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts a beat this cycle
- a  in  1+EXP_W+MAN_W  operand A {sign, exp, frac}
- b  in  1+EXP_W+MAN_W  operand B
- sub  in  1  0: A+B, 1: A−B (B sign inverted before processing)
- out_valid  out  1  result beat present
- out_ready  in  1  downstream accepts result
- result  out  1+EXP_W+MAN_W  rounded result
- flags  out  4  {invalid, overflow, underflow, inexact}, qualified by out_valid

## Operation
- Beat accepted when in_valid && in_ready; result emitted when out_valid && out_ready.
- Let EMAX = 2^EXP_W−1, W = MAN_W+1 significand bits.
- Stage 1 (unpack/classify): exp==0 → zero (subnormal inputs flushed to signed zero, no flag); exp==EMAX, frac==0 → inf; exp==EMAX, frac!=0 → NaN. Swap so operand X has the larger magnitude (compare {exp,frac}); effective op = sign_x XOR sign_y.
- Stage 2 (align): shift Y significand right by d = ex−ey into a W+3-bit field (guard, round, sticky); all bits shifted past the field OR into sticky; d ≥ W+3 gives Y = sticky only (if Y nonzero).
- Stage 3 (add/normalise): W+4-bit add or subtract. Carry out → shift right 1, exp+1, sticky absorbs dropped bit. Otherwise leading-zero count, shift left, exp−lzc. Zero magnitude → exact zero.
- Stage 4 (round/pack): RNE on guard/round/sticky; mantissa carry from rounding increments exp. exp ≥ EMAX → ±inf, overflow=1, inexact=1. Normalised exp ≤ 0 → signed zero (flush), underflow=1, inexact=1. inexact = any nonzero G/R/S discarded.
- Exact-cancellation zero: +0. (+0)+(+0)=+0, (−0)+(−0)=−0, mixed-sign zeros → +0.
- Specials override arithmetic: any NaN → canonical quiet NaN {0, EMAX, 1 followed by zeros}, invalid=1 only if an input NaN had frac MSB=0 (signalling); inf ± finite → that inf; inf + inf same sign → inf; inf − inf effective → canonical NaN, invalid=1. No other flags set on special paths.

## Timing
- Latency: 4 cycles from acceptance to out_valid (beat accepted at edge k is on result at edge k+4 if no stall).
- Throughput 1 beat/cycle. Pipeline enable en = !out_valid || out_ready; in_ready = en (combinational from out_valid/out_ready, no dependence on in_valid).
- en low: all stage registers, valids, result, flags hold; no beat lost or duplicated.
- Bubbles propagate as valid=0 stages; data in invalid stages is don't-care but must not raise out_valid.
- Reset (any time, including mid-stream): all stage valids, out_valid, result and flags → 0 immediately; in-flight beats discarded; in_ready = 1 while reset is held and after release.
- out_valid and result/flags change only on clock edges.

## Test plan
- Basic (EXP_W=8, MAN_W=23): a=0x3F800000, b=0x3F800000, sub=0 → result 0x40000000, flags 0, out_valid exactly 4 cycles after accept; sub=1 → 0x00000000, flags 0.
- Rounding: 0x3F800000 + 0x33800000 → 0x3F800000, inexact=1 (tie to even); 0x3F800001 + 0x33800000 → 0x3F800002, inexact=1.
- Overflow/specials: 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, flags {0,1,0,1}; 0x7F800000 − 0x7F800000 → 0x7FC00000, invalid=1; 0x7F800001 + 1.0 → 0x7FC00000, invalid=1; 0x00000001 + 0x80000000 → 0x00000000, flags 0.
- Backpressure: stream 20 random beats with in_valid every cycle, out_ready toggled pseudo-randomly → results in order, count 20, each matching reference model bit-exactly; no acceptance while in_ready=0.
- Reset mid-stream: assert reset with 3 beats in flight → out_valid=0, result=0 same cycle; after release, a new beat 0x40400000+0x3F800000 → 0x40800000 after 4 cycles, no stale beats emitted.
- Parametrisation: EXP_W=5, MAN_W=10 build: 0x3C00+0x3C00 → 0x4000; 0x7BFF+0x7BFF → 0x7C00, overflow=1.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Pipelined floating-point add/subtract with round-to-nearest-even, flush-to-zero and exception flags.
// Five register ranks (capture, classify, align, add/normalise, round/pack); one global stall enable.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic [3:0]           flags
);
  localparam int DW = EXP_W + MAN_W + 1;
  localparam int W  = MAN_W + 1;
  localparam int FW = W + 3;
  localparam int LW = $clog2(FW + 1);
  localparam int XW = ((EXP_W > LW) ? EXP_W : LW) + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [DW-1:0]    QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic          w_en;
  logic          r_out_vld;
  logic [DW-1:0] r_result;
  logic [3:0]    r_flags;

  assign w_en      = !r_out_vld || out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_vld;
  assign result    = r_result;
  assign flags     = r_flags;

  // Rank 0: operand capture
  logic          r0_vld, r0_sub;
  logic [DW-1:0] r0_a, r0_b;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r0_vld <= 1'b0;
      r0_sub <= 1'b0;
      r0_a   <= '0;
      r0_b   <= '0;
    end else if (w_en) begin
      r0_vld <= in_valid;
      r0_sub <= sub;
      r0_a   <= a;
      r0_b   <= b;
    end
  end

  // Stage 1: unpack, classify, resolve specials, order by magnitude
  logic             w1_sa, w1_sb, w1_snan, w1_swap;
  logic [EXP_W-1:0] w1_ea, w1_eb;
  logic [MAN_W-1:0] w1_fa, w1_fb;
  logic             w1_nan_a, w1_nan_b, w1_inf_a, w1_inf_b, w1_zero_a, w1_zero_b;
  logic [W-1:0]     w1_ma, w1_mb;
  logic             w1_spc;
  logic [DW-1:0]    w1_spc_res;
  logic [3:0]       w1_spc_flg;

  assign w1_sa     = r0_a[DW-1];
  assign w1_sb     = r0_b[DW-1] ^ r0_sub;
  assign w1_ea     = r0_a[DW-2:MAN_W];
  assign w1_eb     = r0_b[DW-2:MAN_W];
  assign w1_fa     = r0_a[MAN_W-1:0];
  assign w1_fb     = r0_b[MAN_W-1:0];
  assign w1_nan_a  = (w1_ea == EMAX) && (w1_fa != '0);
  assign w1_nan_b  = (w1_eb == EMAX) && (w1_fb != '0);
  assign w1_inf_a  = (w1_ea == EMAX) && (w1_fa == '0);
  assign w1_inf_b  = (w1_eb == EMAX) && (w1_fb == '0);
  assign w1_zero_a = (w1_ea == '0);
  assign w1_zero_b = (w1_eb == '0);
  assign w1_snan   = (w1_nan_a && !w1_fa[MAN_W-1]) || (w1_nan_b && !w1_fb[MAN_W-1]);
  assign w1_swap   = {w1_eb, w1_fb} > {w1_ea, w1_fa};
  assign w1_ma     = w1_zero_a ? '0 : {1'b1, w1_fa};
  assign w1_mb     = w1_zero_b ? '0 : {1'b1, w1_fb};

  always_comb begin
    w1_spc     = 1'b1;
    w1_spc_res = QNAN;
    w1_spc_flg = 4'b0000;
    if (w1_nan_a || w1_nan_b) begin
      w1_spc_flg = {w1_snan, 3'b000};
    end else if (w1_inf_a && w1_inf_b) begin
      if (w1_sa != w1_sb) w1_spc_flg = 4'b1000;
      else                w1_spc_res = {w1_sa, EMAX, {MAN_W{1'b0}}};
    end else if (w1_inf_a) begin
      w1_spc_res = {w1_sa, EMAX, {MAN_W{1'b0}}};
    end else if (w1_inf_b) begin
      w1_spc_res = {w1_sb, EMAX, {MAN_W{1'b0}}};
    end else if (w1_zero_a && w1_zero_b) begin
      // Both zero never reaches the adder: only (-0)+(-0) keeps its sign
      w1_spc_res = {w1_sa & w1_sb, {(DW-1){1'b0}}};
    end else begin
      w1_spc     = 1'b0;
      w1_spc_res = '0;
    end
  end

  logic             r1_vld, r1_sx, r1_esub, r1_spc;
  logic [EXP_W-1:0] r1_ex, r1_d;
  logic [W-1:0]     r1_mx, r1_my;
  logic [DW-1:0]    r1_spc_res;
  logic [3:0]       r1_spc_flg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r1_vld     <= 1'b0;
      r1_sx      <= 1'b0;
      r1_esub    <= 1'b0;
      r1_spc     <= 1'b0;
      r1_ex      <= '0;
      r1_d       <= '0;
      r1_mx      <= '0;
      r1_my      <= '0;
      r1_spc_res <= '0;
      r1_spc_flg <= '0;
    end else if (w_en) begin
      r1_vld     <= r0_vld;
      r1_sx      <= w1_swap ? w1_sb : w1_sa;
      r1_esub    <= w1_sa ^ w1_sb;
      r1_spc     <= w1_spc;
      r1_ex      <= w1_swap ? w1_eb : w1_ea;
      r1_d       <= w1_swap ? (w1_eb - w1_ea) : (w1_ea - w1_eb);
      r1_mx      <= w1_swap ? w1_mb : w1_ma;
      r1_my      <= w1_swap ? w1_ma : w1_mb;
      r1_spc_res <= w1_spc_res;
      r1_spc_flg <= w1_spc_flg;
    end
  end

  // Stage 2: align the smaller operand into a guard/round/sticky field
  logic [2*FW-1:0] w2_wide;
  logic            w2_far;
  logic [FW-1:0]   w2_my;

  assign w2_wide = {r1_my, 3'b000, {FW{1'b0}}} >> r1_d;
  assign w2_far  = 32'(r1_d) >= FW;
  assign w2_my   = w2_far ? {{(FW-1){1'b0}}, |r1_my}
                          : (w2_wide[2*FW-1:FW] | {{(FW-1){1'b0}}, |w2_wide[FW-1:0]});

  logic             r2_vld, r2_sx, r2_esub, r2_spc;
  logic [EXP_W-1:0] r2_ex;
  logic [FW-1:0]    r2_mx, r2_my;
  logic [DW-1:0]    r2_spc_res;
  logic [3:0]       r2_spc_flg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r2_vld     <= 1'b0;
      r2_sx      <= 1'b0;
      r2_esub    <= 1'b0;
      r2_spc     <= 1'b0;
      r2_ex      <= '0;
      r2_mx      <= '0;
      r2_my      <= '0;
      r2_spc_res <= '0;
      r2_spc_flg <= '0;
    end else if (w_en) begin
      r2_vld     <= r1_vld;
      r2_sx      <= r1_sx;
      r2_esub    <= r1_esub;
      r2_spc     <= r1_spc;
      r2_ex      <= r1_ex;
      r2_mx      <= {r1_mx, 3'b000};
      r2_my      <= w2_my;
      r2_spc_res <= r1_spc_res;
      r2_spc_flg <= r1_spc_flg;
    end
  end

  // Stage 3: magnitude add/subtract (X >= Y so never negative), then normalise
  logic [FW:0]    w3_sum;
  logic [LW-1:0]  w3_lzc;
  logic [FW-1:0]  w3_norm;
  logic [XW-1:0]  w3_exp, w3_ex_ext;

  assign w3_sum    = r2_esub ? ({1'b0, r2_mx} - {1'b0, r2_my}) : ({1'b0, r2_mx} + {1'b0, r2_my});
  assign w3_ex_ext = {{(XW-EXP_W){1'b0}}, r2_ex};

  always_comb begin
    w3_lzc = LW'(FW);
    for (int i = 0; i < FW; i++) begin
      if (w3_sum[i]) w3_lzc = LW'(FW - 1 - i);
    end
  end

  always_comb begin
    if (w3_sum[FW]) begin
      w3_norm = {w3_sum[FW:2], |w3_sum[1:0]};
      w3_exp  = w3_ex_ext + {{(XW-1){1'b0}}, 1'b1};
    end else begin
      w3_norm = w3_sum[FW-1:0] << w3_lzc;
      w3_exp  = w3_ex_ext - {{(XW-LW){1'b0}}, w3_lzc};
    end
  end

  logic             r3_vld, r3_sx, r3_zero, r3_spc;
  logic [XW-1:0]    r3_exp;
  logic [FW-1:0]    r3_norm;
  logic [DW-1:0]    r3_spc_res;
  logic [3:0]       r3_spc_flg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r3_vld     <= 1'b0;
      r3_sx      <= 1'b0;
      r3_zero    <= 1'b0;
      r3_spc     <= 1'b0;
      r3_exp     <= '0;
      r3_norm    <= '0;
      r3_spc_res <= '0;
      r3_spc_flg <= '0;
    end else if (w_en) begin
      r3_vld     <= r2_vld;
      r3_sx      <= r2_sx;
      r3_zero    <= (w3_sum == '0);
      r3_spc     <= r2_spc;
      r3_exp     <= w3_exp;
      r3_norm    <= w3_norm;
      r3_spc_res <= r2_spc_res;
      r3_spc_flg <= r2_spc_flg;
    end
  end

  // Stage 4: round to nearest even on G/R/S, range check, pack
  logic          w4_up, w4_inx, w4_uf, w4_of;
  logic [W:0]    w4_mant;
  logic [XW-1:0] w4_exp;
  logic [MAN_W-1:0] w4_frac;
  logic [DW-1:0] w4_res;
  logic [3:0]    w4_flg;

  assign w4_up   = r3_norm[2] && (r3_norm[1] || r3_norm[0] || r3_norm[3]);
  assign w4_inx  = |r3_norm[2:0];
  assign w4_mant = {1'b0, r3_norm[FW-1:3]} + {{W{1'b0}}, w4_up};
  assign w4_exp  = r3_exp + {{(XW-1){1'b0}}, w4_mant[W]};
  assign w4_frac = w4_mant[W] ? w4_mant[MAN_W:1] : w4_mant[MAN_W-1:0];
  assign w4_uf   = r3_exp[XW-1] || (r3_exp == '0);
  assign w4_of   = w4_exp >= {{(XW-EXP_W){1'b0}}, EMAX};

  always_comb begin
    w4_res = {r3_sx, w4_exp[EXP_W-1:0], w4_frac};
    w4_flg = {3'b000, w4_inx};
    if (r3_spc) begin
      w4_res = r3_spc_res;
      w4_flg = r3_spc_flg;
    end else if (r3_zero) begin
      w4_res = '0;
      w4_flg = 4'b0000;
    end else if (w4_uf) begin
      w4_res = {r3_sx, {(DW-1){1'b0}}};
      w4_flg = 4'b0011;
    end else if (w4_of) begin
      w4_res = {r3_sx, EMAX, {MAN_W{1'b0}}};
      w4_flg = 4'b0101;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_out_vld <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
    end else if (w_en) begin
      r_out_vld <= r3_vld;
      r_result  <= w4_res;
      r_flags   <= w4_flg;
    end
  end

endmodule
